// File: rtl/tick_pwm_pkg.sv
// Shared constants for tick_pwm: source-select encodings and default widths.
package tick_pwm_pkg;

  localparam int unsigned PERIOD_W_DEF = 4;
  localparam int unsigned CNT_W_DEF    = 8;

  // Encodings match the bit order of div_in = {div16, div8, div4, div2}
  localparam logic [1:0] SEL_DIV2  = 2'd0;
  localparam logic [1:0] SEL_DIV4  = 2'd1;
  localparam logic [1:0] SEL_DIV8  = 2'd2;
  localparam logic [1:0] SEL_DIV16 = 2'd3;

endpackage

// File: rtl/tick_pwm_edge_sync.sv
// One divided-clock bit: 2-flop synchronizer plus history register.
// TICK_PWM_GLITCH_FILTER_EN inserts a 2-cycle stability filter before the history.
module edge_sync (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_level,
  output logic o_hist
);

  logic r_ff1, r_ff2, r_hist;

`ifdef TICK_PWM_GLITCH_FILTER_EN
  logic r_stab, r_filt;

  // The filtered level only follows the synchronizer once it has held for two cycles
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ff1  <= 1'b0;
      r_ff2  <= 1'b0;
      r_stab <= 1'b0;
      r_filt <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_ff1  <= i_d;
      r_ff2  <= r_ff1;
      r_stab <= r_ff2;
      if (r_ff2 == r_stab) r_filt <= r_ff2;
      r_hist <= r_filt;
    end
  end

  assign o_level = r_filt;
`else
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ff1  <= 1'b0;
      r_ff2  <= 1'b0;
      r_hist <= 1'b0;
    end else begin
      r_ff1  <= i_d;
      r_ff2  <= r_ff1;
      r_hist <= r_ff2;
    end
  end

  assign o_level = r_ff2;
`endif

  assign o_hist = r_hist;

endmodule

// File: rtl/tick_pwm.sv
// Tick generator from a selectable divided clock, with tick counter and PWM.
// Optional glitch filter in edge_sync is enabled by TICK_PWM_GLITCH_FILTER_EN.
module tick_pwm
  import tick_pwm_pkg::*;
#(
  parameter int unsigned PERIOD_W = PERIOD_W_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          div_in,
  input  logic [1:0]          sel,
  input  logic                en,
  input  logic [PERIOD_W:0]   duty,
  output logic                tick,
  output logic                pwm,
  output logic [CNT_W-1:0]    tick_cnt
);

  localparam logic [PERIOD_W-1:0] PhaseOne = 1;
  localparam logic [CNT_W-1:0]    CntOne   = 1;

  logic [3:0] w_level, w_hist;
  logic       w_sel_level, w_sel_hist, w_rise, w_tick_d, w_wrap;

  logic                r_tick, r_pwm, r_in_rst;
  logic [1:0]          r_sel_prev;
  logic [PERIOD_W-1:0] r_phase;
  logic [PERIOD_W:0]   r_duty_sh;
  logic [CNT_W-1:0]    r_cnt;

  for (genvar g = 0; g < 4; g++) begin : g_sync
    edge_sync u_edge_sync (
      .i_clk   (clk),
      .i_reset (reset),
      .i_d     (div_in[g]),
      .o_level (w_level[g]),
      .o_hist  (w_hist[g])
    );
  end

  always_comb begin
    w_sel_level = 1'b0;
    w_sel_hist  = 1'b0;
    unique case (sel)
      SEL_DIV2:  begin w_sel_level = w_level[0]; w_sel_hist = w_hist[0]; end
      SEL_DIV4:  begin w_sel_level = w_level[1]; w_sel_hist = w_hist[1]; end
      SEL_DIV8:  begin w_sel_level = w_level[2]; w_sel_hist = w_hist[2]; end
      SEL_DIV16: begin w_sel_level = w_level[3]; w_sel_hist = w_hist[3]; end
      default:   ;
    endcase
  end

  // A sel change masks the edge detector for one cycle so a source swap cannot fake a rise
  assign w_rise   = w_sel_level & ~w_sel_hist;
  assign w_tick_d = en & w_rise & (sel == r_sel_prev);
  assign w_wrap   = w_tick_d & (r_phase == {PERIOD_W{1'b1}});

  always_ff @(posedge clk) begin
    r_sel_prev <= sel;
    if (reset) begin
      r_in_rst  <= 1'b1;
      r_tick    <= 1'b0;
      r_pwm     <= 1'b0;
      r_phase   <= '0;
      r_cnt     <= '0;
      r_duty_sh <= '0;
    end else begin
      r_in_rst <= 1'b0;
      r_tick   <= w_tick_d;
      r_pwm    <= en & ({1'b0, r_phase} < r_duty_sh);
      if (!en) begin
        r_phase <= '0;
      end else if (w_tick_d) begin
        r_phase <= r_phase + PhaseOne;
      end
      if (w_tick_d) r_cnt <= r_cnt + CntOne;
      // New duty only at a period boundary (or the first cycle out of reset)
      if (r_in_rst || w_wrap) r_duty_sh <= duty;
    end
  end

  assign tick     = r_tick;
  assign pwm      = r_pwm;
  assign tick_cnt = r_cnt;

endmodule

// File: tb/tb_tick_pwm.sv
// Self-checking bench for tick_pwm: directed steps plus random traffic against a sample-history model.
module tb_tick_pwm;
  import tick_pwm_pkg::*;

  localparam int PW     = 4;
  localparam int CW     = 8;
  localparam int PERIOD = 1 << PW;
  localparam int CMOD   = 1 << CW;
`ifdef TICK_PWM_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset, en;
  logic [3:0]    div_in;
  logic [1:0]    sel;
  logic [PW:0]   duty;
  logic          tick, pwm;
  logic [CW-1:0] tick_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  tick_pwm #(.PERIOD_W(PW), .CNT_W(CW)) dut (
    .clk      (clk),
    .reset    (reset),
    .div_in   (div_in),
    .sel      (sel),
    .en       (en),
    .duty     (duty),
    .tick     (tick),
    .pwm      (pwm),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  // Model: m_smp[j] is the div_in sample taken j+1 edges ago (0 while in reset)
  logic [3:0] m_smp [3];
  logic [3:0] m_fl, m_fl_prev;
  logic [1:0] m_sel_prev = 2'd0;
  int         m_phase, m_cnt, m_shadow;
  bit         m_tick, m_pwm, m_rst_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_rise(input logic [1:0] s);
`ifdef TICK_PWM_GLITCH_FILTER_EN
    return m_fl[s] & ~m_fl_prev[s];
`else
    return m_smp[1][s] & ~m_smp[2][s];
`endif
  endfunction

  task automatic model_edge();
    int         old_phase = m_phase;
    bit         rise = model_rise(sel);
    logic [3:0] fl_new;
    for (int b = 0; b < 4; b++)
      fl_new[b] = (m_smp[1][b] == m_smp[2][b]) ? m_smp[1][b] : m_fl[b];
    if (reset) begin
      m_tick = 0; m_pwm = 0; m_phase = 0; m_cnt = 0; m_shadow = 0;
      for (int j = 0; j < 3; j++) m_smp[j] = 4'h0;
      m_fl = 4'h0; m_fl_prev = 4'h0;
      m_rst_prev = 1;
    end else begin
      m_tick = en && rise && (sel == m_sel_prev);
      m_pwm  = en && (old_phase < m_shadow);
      if (m_rst_prev || (m_tick && old_phase == PERIOD - 1)) m_shadow = int'(duty);
      m_phase = !en ? 0 : (m_tick ? (old_phase + 1) % PERIOD : old_phase);
      if (m_tick) m_cnt = (m_cnt + 1) % CMOD;
      m_smp[2] = m_smp[1]; m_smp[1] = m_smp[0]; m_smp[0] = div_in;
      m_fl_prev = m_fl; m_fl = fl_new;
      m_rst_prev = 0;
    end
    m_sel_prev = sel;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    chk("tick", tick, m_tick);
    chk("pwm", pwm, m_pwm);
    chk("tick_cnt", tick_cnt, m_cnt);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) begin
      step();
      chk("rst_tick", tick, 0);
      chk("rst_pwm", pwm, 0);
      chk("rst_cnt", tick_cnt, 0);
    end
    reset = 1'b0;
  endtask

  initial begin
    en = 1'b1; sel = SEL_DIV2; div_in = 4'h0; duty = 5'd5; reset = 1'b1;

    // Reset held 3 cycles, outputs idle until the first edge
    do_reset(3);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("post_rst_tick", tick, 0);
      chk("post_rst_cnt", tick_cnt, 0);
    end

    // div2 toggling every 4 clocks: 10 rises, fixed latency
    for (int i = 0; i < 80; i++) begin
      div_in[0] = ((i / 4) % 2) == 0;
      step();
      if (i == LAT - 2) chk("lat_early", tick, 0);
      if (i == LAT - 1) chk("lat_tick", tick, 1);
    end
    div_in[0] = 1'b0;
    repeat (LAT + 1) step();
    chk("cnt10", tick_cnt, 10);

    // Fast ticks with duty=5, then a mid-period change to 12
    for (int i = 0; i < 64; i++) begin div_in[0] = i[0]; step(); end
    duty = 5'd12;
    for (int i = 0; i < 96; i++) begin div_in[0] = i[0]; step(); end

    // duty=0 -> constant low, duty=16 -> constant high
    duty = 5'd0;
    for (int i = 0; i < 80; i++) begin div_in[0] = i[0]; step(); end
    for (int i = 0; i < 34; i++) begin div_in[0] = i[0]; step(); chk("duty0", pwm, 0); end
    duty = 5'd16;
    for (int i = 0; i < 80; i++) begin div_in[0] = i[0]; step(); end
    for (int i = 0; i < 34; i++) begin div_in[0] = i[0]; step(); chk("duty16", pwm, 1); end

    // Source switch 0->3 with div16 high and div2 low: no tick
    div_in = 4'h0;
    do_reset(2);
    div_in = 4'b1000;
    repeat (8) step();
    sel = SEL_DIV16;
    step(); chk("sel_sw", tick, 0);
    step(); chk("sel_sw2", tick, 0);
    sel = SEL_DIV2;
    div_in = 4'h0;
    repeat (4) step();

    // Exactly 256 rises: counter wraps back to 0
    for (int i = 0; i < 512; i++) begin div_in[0] = (i % 2) == 0; step(); end
    div_in[0] = 1'b0;
    repeat (LAT + 2) step();
    chk("wrap256", tick_cnt, 0);

`ifdef TICK_PWM_GLITCH_FILTER_EN
    // 1-cycle pulse rejected, 3-cycle pulse gives one tick
    div_in[0] = 1'b1; step(); div_in[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin step(); chk("glitch1", tick, 0); end
    for (int i = 0; i < 10; i++) begin
      div_in[0] = (i < 3);
      step();
      chk("glitch3", tick, (i == LAT - 1));
    end
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 3) == 0) div_in[b] = ~div_in[b];
      if ($urandom_range(0, 49) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) duty = 5'($urandom_range(0, 20));
      reset = ($urandom_range(0, 399) == 0);
      step();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
